// File: rtl/taxi_axil_if.sv
// AXI4-Lite bundle split into write (AW/W/B) and read (AR/R) modport pairs.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W/8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );
  modport wr_slv (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
  modport rd_mst (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
  modport rd_slv (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction,
// one response out, with a per-transaction watchdog against hung slaves.
module axil_cmd_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int STRB_W      = DATA_W/8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  taxi_axil_if.wr_mst       wr_axil,
  taxi_axil_if.rd_mst       rd_axil
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  // One spare bit so the increment past the limit never wraps to a small value
  localparam int                CNT_W  = $clog2(TIMEOUT_CYC + 2) + 1;
  localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT_CYC);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt;
  logic              aw_done, w_done;
  logic              aw_vld, w_vld, b_rdy, ar_vld, r_rdy;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              aw_all, w_all;
  logic [CNT_W-1:0]  cnt_inc;
  logic              to_hit, abort;

  assign aw_hs   = aw_vld & wr_axil.awready;
  assign w_hs    = w_vld  & wr_axil.wready;
  assign b_hs    = b_rdy  & wr_axil.bvalid;
  assign ar_hs   = ar_vld & rd_axil.arready;
  assign r_hs    = r_rdy  & rd_axil.rvalid;
  assign aw_all  = aw_done | aw_hs;
  assign w_all   = w_done  | w_hs;
  assign cnt_inc = cnt + CNT_W'(1);
  assign to_hit  = (TIMEOUT_CYC != 0) && (cnt_inc >= TO_LIM);

  // Completion in the limit cycle wins over the timeout
  always_comb begin
    abort = 1'b0;
    case (state)
      WR_AW_W: abort = to_hit && !(aw_all && w_all);
      WR_B:    abort = to_hit && !b_hs;
      RD_AR:   abort = to_hit && !ar_hs;
      RD_R:    abort = to_hit && !r_hs;
      default: abort = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wr_q        <= 1'b0;
      cnt         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_vld      <= 1'b0;
      w_vld       <= 1'b0;
      b_rdy       <= 1'b0;
      ar_vld      <= 1'b0;
      r_rdy       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else if (abort) begin
      // Watchdog: drop every valid/ready mid-handshake and report SLVERR
      aw_vld      <= 1'b0;
      w_vld       <= 1'b0;
      b_rdy       <= 1'b0;
      ar_vld      <= 1'b0;
      r_rdy       <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_write   <= wr_q;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b10;
      rsp_timeout <= 1'b1;
      state       <= RSP;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            wr_q    <= cmd_write;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              aw_vld <= 1'b1;
              w_vld  <= 1'b1;
              state  <= WR_AW_W;
            end else begin
              ar_vld <= 1'b1;
              state  <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          cnt <= cnt_inc;
          if (aw_hs) begin
            aw_vld  <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_vld  <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_all && w_all) begin
            b_rdy <= 1'b1;
            state <= WR_B;
          end
        end
        WR_B: begin
          cnt <= cnt_inc;
          if (b_hs) begin
            b_rdy       <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= wr_axil.bresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RD_AR: begin
          cnt <= cnt_inc;
          if (ar_hs) begin
            ar_vld <= 1'b0;
            r_rdy  <= 1'b1;
            state  <= RD_R;
          end
        end
        RD_R: begin
          cnt <= cnt_inc;
          if (r_hs) begin
            r_rdy       <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b0;
            rsp_rdata   <= rd_axil.rdata;
            rsp_resp    <= rd_axil.rresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign wr_axil.awaddr  = addr_q;
  assign wr_axil.awprot  = 3'b000;
  assign wr_axil.awvalid = aw_vld;
  assign wr_axil.wdata   = wdata_q;
  assign wr_axil.wstrb   = wstrb_q;
  assign wr_axil.wvalid  = w_vld;
  assign wr_axil.bready  = b_rdy;
  assign rd_axil.araddr  = addr_q;
  assign rd_axil.arprot  = 3'b000;
  assign rd_axil.arvalid = ar_vld;
  assign rd_axil.rready  = r_rdy;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable-latency AXI-Lite slave.
module tb_axil_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  axil_cmd_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy), .wr_axil(axil), .rd_axil(axil)
  );

  // slave model knobs
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  bit          ar_never = 0, b_hold = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt, w_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;

  assign axil.awready = axil.awvalid && (aw_cnt >= aw_wait);
  assign axil.wready  = axil.wvalid && (w_cnt >= w_wait);
  assign axil.bvalid  = b_pend && !b_hold;
  assign axil.bresp   = bresp_cfg;
  assign axil.arready = axil.arvalid && !ar_never;
  assign axil.rvalid  = r_pend && (r_cnt >= r_wait);
  assign axil.rdata   = rdata_cfg;
  assign axil.rresp   = rresp_cfg;

  wire aw_hs = axil.awvalid && axil.awready;
  wire w_hs  = axil.wvalid && axil.wready;
  wire b_hs  = axil.bvalid && axil.bready;
  wire ar_hs = axil.arvalid && axil.arready;
  wire r_hs  = axil.rvalid && axil.rready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (axil.awvalid && !axil.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axil.wvalid && !axil.wready) ? w_cnt + 1 : 0;
      if (aw_hs) aw_got <= 1'b1;
      if (w_hs)  w_got  <= 1'b1;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_hs) b_pend <= 1'b0;
      if (ar_hs) begin r_pend <= 1'b1; r_cnt <= 0; end
      else if (r_pend && !r_hs) r_cnt <= r_cnt + 1;
      if (r_hs) r_pend <= 1'b0;
    end
  end

  // event monitor: cycle stamps of each handshake and captured payloads
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int cmd_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rsp_cyc;
  int awv_n, wv_n, arv_n, b_n, rsp_n = 0;
  logic [31:0] awaddr_s, wdata_s, araddr_s, r_rdata;
  logic [3:0]  wstrb_s;
  logic [2:0]  awprot_s;
  logic        r_write, r_to;
  logic [1:0]  r_resp;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) cmd_cyc = cyc;
    if (axil.awvalid) awv_n++;
    if (axil.wvalid)  wv_n++;
    if (axil.arvalid) arv_n++;
    if (aw_hs) begin aw_cyc = cyc; awaddr_s = axil.awaddr; awprot_s = axil.awprot; end
    if (w_hs)  begin w_cyc = cyc; wdata_s = axil.wdata; wstrb_s = axil.wstrb; end
    if (b_hs)  begin b_cyc = cyc; b_n++; end
    if (ar_hs) begin ar_cyc = cyc; araddr_s = axil.araddr; end
    if (r_hs)  r_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      rsp_cyc = cyc; rsp_n++;
      r_write = rsp_write; r_rdata = rsp_rdata; r_resp = rsp_resp; r_to = rsp_timeout;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    awv_n = 0; wv_n = 0; arv_n = 0; b_n = 0;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    bit ok = 0;
    logic hs;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      hs = cmd_ready;
      @(posedge clk); #1;
      if (hs) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1);
  endtask

  task automatic wait_rsp(input int n0);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_n != n0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("rsp_seen", ok, 1);
  endtask

  initial begin
    int  n0;
    bit  stable, seen_rdy, ok;
    logic hs;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);

    // zero-wait write
    clr(); n0 = rsp_n;
    send(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(n0);
    chk("wr0_aw_lat", aw_cyc - cmd_cyc, 1);
    chk("wr0_w_lat", w_cyc - cmd_cyc, 1);
    chk("wr0_b_lat", b_cyc - cmd_cyc, 2);
    chk("wr0_rsp_lat", rsp_cyc - cmd_cyc, 3);
    chk("wr0_payload", {awaddr_s, wdata_s, wstrb_s, awprot_s}, {32'h4, 32'hDEAD_BEEF, 4'hF, 3'b0});
    chk("wr0_rsp", {r_write, r_rdata, r_resp, r_to}, {1'b1, 32'h0, 2'b00, 1'b0});

    // W held off 5 cycles after AW
    clr(); n0 = rsp_n; w_wait = 5;
    send(1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3);
    wait_rsp(n0);
    chk("wr1_awv_cycles", awv_n, 1);
    chk("wr1_wv_cycles", wv_n, 6);
    chk("wr1_w_lat", w_cyc - cmd_cyc, 6);
    chk("wr1_b_count", b_n, 1);
    chk("wr1_rsp", {r_write, r_resp, r_to, wdata_s, wstrb_s}, {1'b1, 2'b00, 1'b0, 32'h0BAD_F00D, 4'h3});
    w_wait = 0;

    // read with 3 R wait cycles
    clr(); n0 = rsp_n; r_wait = 3; rdata_cfg = 32'h1234_5678;
    send(0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
    wait_rsp(n0);
    chk("rd0_araddr", araddr_s, 32'h8);
    chk("rd0_ar_lat", ar_cyc - cmd_cyc, 1);
    chk("rd0_r_lat", r_cyc - cmd_cyc, 5);
    chk("rd0_rsp", {r_write, r_rdata, r_resp, r_to}, {1'b0, 32'h1234_5678, 2'b00, 1'b0});
    r_wait = 0;

    // AR never accepted: watchdog after 16 cycles
    clr(); n0 = rsp_n; ar_never = 1; rdata_cfg = 32'h7777_7777;
    send(0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp(n0);
    chk("to_arv_cycles", arv_n, 16);
    chk("to_rsp_lat", rsp_cyc - cmd_cyc, 17);
    chk("to_rsp", {r_write, r_rdata, r_resp, r_to}, {1'b0, 32'h0, 2'b10, 1'b1});
    chk("to_ar_dropped", {axil.arvalid, axil.rready}, 0);
    ar_never = 0;

    // next read after timeout is normal
    clr(); n0 = rsp_n; rdata_cfg = 32'hA5A5_0001;
    send(0, 32'h0000_0010, 32'h0, 4'h0);
    wait_rsp(n0);
    chk("rd1_rsp_lat", rsp_cyc - cmd_cyc, 3);
    chk("rd1_rsp", {r_write, r_rdata, r_resp, r_to}, {1'b0, 32'hA5A5_0001, 2'b00, 1'b0});

    // slave error on write
    clr(); n0 = rsp_n; bresp_cfg = 2'b10;
    send(1, 32'h0000_0014, 32'h1, 4'h1);
    wait_rsp(n0);
    chk("wrerr_rsp", {r_write, r_rdata, r_resp, r_to}, {1'b1, 32'h0, 2'b10, 1'b0});
    bresp_cfg = 2'b00;

    // B lands exactly in the limit cycle: completion, not timeout
    clr(); n0 = rsp_n; w_wait = 14;
    send(1, 32'h0000_0018, 32'h2, 4'h2);
    wait_rsp(n0);
    chk("edge_b_lat", b_cyc - cmd_cyc, 16);
    chk("edge_rsp", {r_resp, r_to}, {2'b00, 1'b0});
    w_wait = 0;

    // reset while waiting in WR_B
    b_hold = 1;
    send(1, 32'h0000_001C, 32'h3, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_in_wr_b", {axil.bready, busy}, 2'b11);
    n0 = rsp_n;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valids", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp_valid}, 0);
    chk("rstmid_ready", cmd_ready, 1);
    #1;
    rst_n = 1'b1; b_hold = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rstmid_no_rsp", rsp_n - n0, 0);
    chk("rstmid_idle", {busy, cmd_ready, rsp_valid}, 3'b010);

    // response held 10 cycles with a new command waiting
    n0 = rsp_n; rsp_ready = 1'b0; rdata_cfg = 32'hCAFE_F00D;
    send(0, 32'h0000_0024, 32'h0, 4'h0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("hold_rsp_valid", ok, 1);
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h55; cmd_wstrb = 4'h3; cmd_valid = 1'b1;
    stable = 1; seen_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_rdata === 32'hCAFE_F00D && rsp_write === 1'b0 &&
            rsp_resp === 2'b00 && rsp_timeout === 1'b0)) stable = 0;
      if (cmd_ready !== 1'b0) seen_rdy = 1;
      @(posedge clk); #1;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_accept", seen_rdy, 0);
    chk("hold_no_hs", rsp_n - n0, 0);
    rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      hs = cmd_ready;
      @(posedge clk); #1;
      if (hs) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    chk("b2b_accept", ok, 1);
    chk("b2b_gap", cmd_cyc - rsp_cyc, 1);
    chk("hold_rdata", r_rdata, 32'hCAFE_F00D);
    n0 = rsp_n;
    wait_rsp(n0);
    chk("b2b_wr_rsp", {r_write, r_resp, r_to, awaddr_s, wdata_s, wstrb_s},
        {1'b1, 2'b00, 1'b0, 32'h30, 32'h55, 4'h3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator that turns a simple single-beat command/response stream into AXI4-Lite write and read transactions on a `taxi_axil_if`. It is the master-side counterpart to the AES_UART register slave. It replaces the JTAG-to-AXI bridge in hardware self-test and boot-sequencer builds. It runs one transaction at a time and has a bounded-wait timeout so a hung slave cannot lock up the command source.

## Interface
- DATA_W, 32, AXI data width; must be 32 or 64.
- ADDR_W, 32, AXI address width.
- STRB_W, DATA_W/8, write-strobe width; derived, do not override.
- TIMEOUT_CYC, 1024, cycles allowed per transaction; 0 disables the timeout.

- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_wstrb  in  STRB_W  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- busy  out  1  state != IDLE.
- wr_axil  taxi_axil_if.wr_mst  AW/W/B channels.
- rd_axil  taxi_axil_if.rd_mst  AR/R channels.

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready = 1. On a cmd handshake, register addr, wdata, wstrb and write. Clear the timeout counter. Go to WR_AW_W if write, else RD_AR.
- WR_AW_W: awvalid and wvalid both assert on state entry.
  - Each channel deasserts on its own handshake, tracked by aw_done and w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_B.
- WR_B: bready = 1. On the B handshake, capture bresp and go to RSP.
- RD_AR: arvalid = 1. On the handshake, go to RD_R.
- RD_R: rready = 1. On the R handshake, capture rdata and rresp, then go to RSP.
- RSP: rsp_valid = 1 with all rsp_* fields stable. On rsp_ready, go to IDLE.
- awprot and arprot are tied to 3'b000. awaddr, araddr, wdata and wstrb come from the registered command and stay stable while their valid is high.
- Timeout:
  - The counter increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYC with no completion, all AXI valids and readies drop the next cycle.
  - The block then goes to RSP with rsp_resp = 2'b10, rsp_timeout = 1, and rsp_rdata = 0.
  - This is a deliberate AXI protocol break, acceptable only for debug use.
- A B or R handshake in the same cycle the counter reaches TIMEOUT_CYC counts as completion. No timeout is reported.
- rsp_write is 1 for writes and 0 for reads. rsp_rdata is 0 for writes.
- rsp_timeout is 0 on every normal completion.
- All outputs are registered. cmd_ready and busy are decoded from the state register only.

## Timing
- Reset (Rst_n low, async):
  - state = IDLE; all AXI valids and readies = 0; rsp_valid = 0.
  - rsp_* = 0 and the counter = 0.
  - cmd_ready = 1 and busy = 0 from the first cycle after deassertion.
- Reset mid-transaction aborts immediately. No response is produced.
- Write latency with a zero-wait slave (B returned the cycle after AW/W):
  - Cycle 0: cmd handshake.
  - Cycle 1: AW and W handshakes.
  - Cycle 2: B handshake.
  - Cycle 3: rsp_valid.
- Read latency with a zero-wait slave:
  - Cycle 0: cmd handshake.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: rsp_valid.
- Back-to-back: the next cmd handshake can occur the cycle after the rsp handshake. Minimum 4 cycles per transaction.
- cmd_valid while busy is not accepted. The source holds it until cmd_ready.
- rsp_valid stays high indefinitely until rsp_ready. The timeout does not run in RSP.

## Test plan
- Write 0x0000_0004 ← 0xDEADBEEF, strb 4'hF, zero-wait slave -> AW and W handshakes in cycle 1, bready in cycle 2, rsp_valid in cycle 3 with rsp_write = 1, rsp_resp = 0, rsp_timeout = 0.
- Write with the slave holding wready low 5 cycles after awready -> awvalid drops after 1 cycle, wvalid stays high until cycle 6, a single B handshake, correct response.
- Read 0x0000_0008, slave returns 0x1234_5678 with rresp = 0 after 3 wait cycles -> rsp_rdata = 0x12345678, rsp_write = 0, rsp_resp = 0.
- Slave returns bresp = 2'b10 on a write -> rsp_resp = 2'b10, rsp_timeout = 0.
- TIMEOUT_CYC = 16, slave never asserts arready -> arvalid drops after 16 cycles, rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0. The next command is then processed normally.
- Rst_n pulsed low during WR_B; separately, rsp_ready held low 10 cycles -> the reset case returns all valids to 0 and cmd_ready to 1 with no response emitted. The held-response case keeps rsp_valid and the response fields stable all 10 cycles and accepts no new command until rsp_ready.
